// File: rtl/expr_stream_parser_if.sv
// Handshake bundle between RX FIFO, parser and arithmetic unit.
// EXPR_SIGNED_N1_EN adds the num1 sign flag.
interface expr_stream_parser_if #(
  parameter int CHAR_WIDTH = 8,
  parameter int NUM_WIDTH  = 16,
  parameter int OP_WIDTH   = 3
);
  logic [CHAR_WIDTH-1:0] rx_data_i;
  logic                  rx_empty_i;
  logic                  rx_ren_o;
  logic [NUM_WIDTH-1:0]  num1_o;
  logic [NUM_WIDTH-1:0]  num2_o;
  logic [OP_WIDTH-1:0]   op_o;
  logic                  cmd_valid_o;
  logic                  cmd_ready_i;
  logic                  err_valid_o;
  logic [1:0]            err_code_o;
`ifdef EXPR_SIGNED_N1_EN
  logic                  num1_neg_o;
`endif

  modport slave (
    input  rx_data_i, rx_empty_i, cmd_ready_i,
`ifdef EXPR_SIGNED_N1_EN
    output num1_neg_o,
`endif
    output rx_ren_o, num1_o, num2_o, op_o,
    output cmd_valid_o, err_valid_o, err_code_o
  );

  modport master (
    output rx_data_i, rx_empty_i, cmd_ready_i,
`ifdef EXPR_SIGNED_N1_EN
    input  num1_neg_o,
`endif
    input  rx_ren_o, num1_o, num2_o, op_o,
    input  cmd_valid_o, err_valid_o, err_code_o
  );
endinterface

// File: rtl/expr_stream_parser.sv
// Streaming "<num1><op><num2><term>" parser with error resync.
// EXPR_SIGNED_N1_EN allows a leading '-' sign on num1.
module expr_stream_parser #(
  parameter int CHAR_WIDTH = 8,
  parameter int NUM_WIDTH  = 16,
  parameter int OP_WIDTH   = 3
) (
  input logic               clk,
  input logic               rst,
  expr_stream_parser_if.slave bus
);
  localparam int W = NUM_WIDTH + 4;
  localparam logic [W-1:0] UMAX =
    W'({NUM_WIDTH{1'b1}});
`ifdef EXPR_SIGNED_N1_EN
  localparam logic [W-1:0] NEG_MAX =
    W'(1) << (NUM_WIDTH - 1);
  localparam logic [W-1:0] POS_MAX =
    NEG_MAX - W'(1);
`endif

  typedef logic [CHAR_WIDTH-1:0] ch_t;
  localparam ch_t C_PLUS  = CHAR_WIDTH'(8'h2B);
  localparam ch_t C_MINUS = CHAR_WIDTH'(8'h2D);
  localparam ch_t C_MUL   = CHAR_WIDTH'(8'h2A);
  localparam ch_t C_DIV   = CHAR_WIDTH'(8'h2F);
  localparam ch_t C_MOD   = CHAR_WIDTH'(8'h25);
  localparam ch_t C_SP    = CHAR_WIDTH'(8'h20);
  localparam ch_t C_EQ    = CHAR_WIDTH'(8'h3D);
  localparam ch_t C_CR    = CHAR_WIDTH'(8'h0D);
  localparam ch_t C_D0    = CHAR_WIDTH'(8'h30);
  localparam ch_t C_D9    = CHAR_WIDTH'(8'h39);

  typedef enum logic [1:0] {
    S_N1, S_N2, S_OUT, S_DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [NUM_WIDTH-1:0]  acc1_q, acc1_d;
  logic [NUM_WIDTH-1:0]  acc2_q, acc2_d;
  logic                  seen1_q, seen1_d;
  logic                  seen2_q, seen2_d;
  logic                  neg_q, neg_d;
  logic                  neg_out_q, neg_out_d;
  logic [OP_WIDTH-1:0]   op_q, op_d;
  logic [OP_WIDTH-1:0]   op_out_q, op_out_d;
  logic [NUM_WIDTH-1:0]  num1_q, num1_d;
  logic [NUM_WIDTH-1:0]  num2_q, num2_d;
  logic                  err_v_q, err_v_d;
  logic [1:0]            err_c_q, err_c_d;

  ch_t                   ch;
  logic                  pop;
  logic                  is_dig, is_op;
  logic                  is_sp, is_term;
  logic [OP_WIDTH-1:0]   opc;
  logic [NUM_WIDTH-1:0]  acc_sel;
  logic [W-1:0]          prod;
  logic                  ovf, ovf_err, syn_err;

  assign ch  = bus.rx_data_i;
  assign pop = !bus.rx_empty_i && (state_q != S_OUT);

  assign bus.rx_ren_o    = pop;
  assign bus.num1_o      = num1_q;
  assign bus.num2_o      = num2_q;
  assign bus.op_o        = op_out_q;
  assign bus.cmd_valid_o = (state_q == S_OUT);
  assign bus.err_valid_o = err_v_q;
  assign bus.err_code_o  = err_c_q;
`ifdef EXPR_SIGNED_N1_EN
  assign bus.num1_neg_o  = neg_out_q;
`endif

  // Classify the FIFO head character.
  always_comb begin
    is_dig  = 1'b0;
    is_op   = 1'b0;
    is_sp   = 1'b0;
    is_term = 1'b0;
    opc     = '0;
    unique case (1'b1)
      (ch >= C_D0 && ch <= C_D9): is_dig = 1'b1;
      (ch == C_PLUS): begin
        is_op = 1'b1; opc = OP_WIDTH'(0);
      end
      (ch == C_MINUS): begin
        is_op = 1'b1; opc = OP_WIDTH'(1);
      end
      (ch == C_MUL): begin
        is_op = 1'b1; opc = OP_WIDTH'(2);
      end
      (ch == C_DIV): begin
        is_op = 1'b1; opc = OP_WIDTH'(3);
      end
      (ch == C_MOD): begin
        is_op = 1'b1; opc = OP_WIDTH'(4);
      end
      (ch == C_SP): is_sp = 1'b1;
      (ch == C_EQ || ch == C_CR): is_term = 1'b1;
      default: ;
    endcase
  end

  // Decimal accumulate at widened width and bound check.
  always_comb begin
    acc_sel = (state_q == S_N1) ? acc1_q : acc2_q;
    prod = {4'b0, acc_sel} * W'(10)
         + W'(ch[3:0]);
    ovf  = prod > UMAX;
`ifdef EXPR_SIGNED_N1_EN
    if (state_q == S_N1)
      ovf = neg_q ? (prod > NEG_MAX)
                  : (prod > POS_MAX);
`endif
  end

  // Next-state, accumulate and error logic.
  always_comb begin
    state_d   = state_q;
    acc1_d    = acc1_q;
    acc2_d    = acc2_q;
    seen1_d   = seen1_q;
    seen2_d   = seen2_q;
    neg_d     = neg_q;
    neg_out_d = neg_out_q;
    op_d      = op_q;
    op_out_d  = op_out_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    err_v_d   = 1'b0;
    err_c_d   = 2'b00;
    ovf_err   = 1'b0;
    syn_err   = 1'b0;
    unique case (state_q)
      S_N1: if (pop) begin
        unique case (1'b1)
          is_sp: ;
          is_dig: begin
            if (ovf) ovf_err = 1'b1;
            else begin
              acc1_d  = prod[NUM_WIDTH-1:0];
              seen1_d = 1'b1;
            end
          end
          is_op: begin
`ifdef EXPR_SIGNED_N1_EN
            if (!seen1_q && ch == C_MINUS) begin
              syn_err = neg_q;
              neg_d   = 1'b1;
            end else
`endif
            if (seen1_q) begin
              op_d    = opc;
              state_d = S_N2;
            end else syn_err = 1'b1;
          end
          default: syn_err = 1'b1;
        endcase
      end
      S_N2: if (pop) begin
        unique case (1'b1)
          is_sp: ;
          is_dig: begin
            if (ovf) ovf_err = 1'b1;
            else begin
              acc2_d  = prod[NUM_WIDTH-1:0];
              seen2_d = 1'b1;
            end
          end
          is_term: begin
            if (seen2_q) begin
              state_d   = S_OUT;
              num1_d    = neg_q ? -acc1_q : acc1_q;
              neg_out_d = neg_q;
              num2_d    = acc2_q;
              op_out_d  = op_q;
            end else syn_err = 1'b1;
          end
          default: syn_err = 1'b1;
        endcase
      end
      S_OUT: if (bus.cmd_ready_i) begin
        acc1_d  = '0;
        acc2_d  = '0;
        seen1_d = 1'b0;
        seen2_d = 1'b0;
        neg_d   = 1'b0;
        state_d = S_N1;
      end
      S_DRAIN: if (pop && is_term)
        state_d = S_N1;
    endcase
    if (ovf_err || syn_err) begin
      err_v_d = 1'b1;
      err_c_d = ovf_err ? 2'b10 : 2'b01;
      acc1_d  = '0;
      acc2_d  = '0;
      seen1_d = 1'b0;
      seen2_d = 1'b0;
      neg_d   = 1'b0;
      state_d = is_term ? S_N1 : S_DRAIN;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_N1;
      acc1_q    <= '0;
      acc2_q    <= '0;
      seen1_q   <= 1'b0;
      seen2_q   <= 1'b0;
      neg_q     <= 1'b0;
      neg_out_q <= 1'b0;
      op_q      <= '0;
      op_out_q  <= '0;
      num1_q    <= '0;
      num2_q    <= '0;
      err_v_q   <= 1'b0;
      err_c_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      acc1_q    <= acc1_d;
      acc2_q    <= acc2_d;
      seen1_q   <= seen1_d;
      seen2_q   <= seen2_d;
      neg_q     <= neg_d;
      neg_out_q <= neg_out_d;
      op_q      <= op_d;
      op_out_q  <= op_out_d;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      err_v_q   <= err_v_d;
      err_c_q   <= err_c_d;
    end
  end
endmodule
